// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states, default clocking and frame-length constants.
// Used by both uart_tx and uart_rx.
package uart_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 9600;

    localparam int DATA_BITS         = 8;
    localparam int FRAME_BITS_BASE   = DATA_BITS + 2;
    localparam int FRAME_BITS_PARITY = DATA_BITS + 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; DEPTH must be a power of two so the
// pointers wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == DEPTH_C);
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter, 8N1 frames; defining UART_TX_PARITY_EN adds an
// even-parity bit (8E1).
//
//   state  | meaning
//   IDLE   | line high, waiting for a byte in the FIFO
//   START  | start bit (low) for one bit period
//   DATA   | data bits, LSB first, one bit period each
//   PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   STOP   | stop bit (high); chains straight into START if more bytes wait
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int BIT_PERIOD = CLK_FREQ / BAUD_RATE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy
);

    localparam int CW = $clog2(BIT_PERIOD);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_PERIOD - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e   r_state, w_state_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [2:0]    r_bit_idx, w_bit_idx_next;
    logic [CW-1:0] r_baud_cnt, w_baud_cnt_next;
    logic          r_tx, w_tx_next;
    logic          r_out_en;
    logic          w_baud_tick;
    logic          w_push, w_pop, w_full, w_empty;
    logic [7:0]    w_fifo_data;
`ifdef UART_TX_PARITY_EN
    logic          r_parity, w_parity_next;
`endif

    // ready is held low through reset and rises on the first edge after release
    assign ready_out   = r_out_en & ~w_full;
    assign w_push      = valid_in & ready_out;
    assign busy        = (r_state != IDLE) | ~w_empty;
    assign tx          = r_tx;
    assign w_baud_tick = (r_baud_cnt == BAUD_LAST);

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // tx is registered from the next-state decision so it changes on the same
    // edge as the state, keeping the line one flop away from any input
    always_comb begin
        w_state_next    = r_state;
        w_shift_next    = r_shift;
        w_bit_idx_next  = r_bit_idx;
        w_tx_next       = r_tx;
        w_pop           = 1'b0;
        w_baud_cnt_next = (r_state == IDLE || w_baud_tick) ? '0 : r_baud_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parity_next   = r_parity;
`endif
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_fifo_data;
`ifdef UART_TX_PARITY_EN
                    w_parity_next = even_parity(w_fifo_data);
`endif
                    w_state_next = START;
                    w_tx_next    = 1'b0;
                end
            end
            START: begin
                if (w_baud_tick) begin
                    w_state_next   = DATA;
                    w_bit_idx_next = '0;
                    w_tx_next      = r_shift[0];
                end
            end
            DATA: begin
                if (w_baud_tick) begin
                    if (r_bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = PARITY;
                        w_tx_next    = r_parity;
`else
                        w_state_next = STOP;
                        w_tx_next    = 1'b1;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (w_baud_tick) begin
                    w_state_next = STOP;
                    w_tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (w_baud_tick) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_fifo_data;
`ifdef UART_TX_PARITY_EN
                        w_parity_next = even_parity(w_fifo_data);
`endif
                        w_state_next = START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = IDLE;
                        w_tx_next    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_baud_cnt <= '0;
            r_tx       <= 1'b1;
            r_out_en   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_bit_idx  <= w_bit_idx_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_tx       <= w_tx_next;
            r_out_en   <= 1'b1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_parity <= 1'b0;
        else          r_parity <= w_parity_next;
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 16 clocks per bit; frame length
// follows UART_TX_PARITY_EN.
module tb_uart_tx;

    localparam int BIT_P = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * BIT_P;

    logic       clk;
    logic       reset_n;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;
    logic       tx;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_tx #(
        .CLK_FREQ   (160),
        .BAUD_RATE  (10),
        .BIT_PERIOD (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx        (tx),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Advance negedges until tx is low; n = samples taken, -1 on timeout.
    task automatic wait_start(input int budget, output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (tx === 1'b0) return;
            if (n >= budget) begin
                n = -1;
                return;
            end
        end
    endtask

    // Caller is on the first low sample of a start bit; records one level per
    // bit and whether every bit held for a full bit period.
    task automatic capture_frame(output logic [10:0] bits, output logic stable);
        bits   = '0;
        stable = 1'b1;
        for (int b = 0; b < FRAME_BITS; b++) begin
            for (int s = 0; s < BIT_P; s++) begin
                if (!(b == 0 && s == 0)) @(negedge clk);
                if (s == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        valid_in = 1'b1;
        data_in  = 8'hEE;
        repeat (2) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ready_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold tx=%b busy=%b ready=%b expected tx=1 busy=0 ready=0", tx, busy, ready_out);
        end
        valid_in = 1'b0;
        reset_n  = 1'b1;
        #1;
        checks++;
        if (ready_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_pre_edge ready=%b expected 0", ready_out);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_edge ready=%b busy=%b tx=%b expected ready=1 busy=0 tx=1", ready_out, busy, tx);
        end
    endtask

    task automatic test_single();
        int n;
        logic [10:0] bits;
        logic st;
        logic [10:0] exp;
`ifdef UART_TX_PARITY_EN
        exp = 11'b10010101010;
`else
        exp = 11'b01010101010;
`endif
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'h55;
        @(negedge clk);
        valid_in = 1'b0;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_accept tx=%b busy=%b expected tx=1 busy=1", tx, busy);
        end
        wait_start(20, n);
        checks++;
        if (n !== 1) begin
            failures++;
            $display("FAIL single_latency extra_edges=%0d expected 1", n);
        end
        capture_frame(bits, st);
        checks++;
        if (bits !== exp || st !== 1'b1) begin
            failures++;
            $display("FAIL single_frame bits=%b stable=%b expected %b stable=1", bits, st, exp);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL single_done busy=%b tx=%b expected busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [5];
        q = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};
        do_reset();
        fork
            begin : pusher
                int idx;
                int guard;
                logic will;
                idx   = 0;
                guard = 0;
                valid_in = 1'b1;
                data_in  = q[0];
                while (idx < 5 && guard < 50) begin
                    will = ready_out;
                    @(negedge clk);
                    guard++;
                    if (will) begin
                        idx++;
                        if (idx < 5) data_in = q[idx];
                        else valid_in = 1'b0;
                    end
                end
                checks++;
                if (idx !== 5 || ready_out !== 1'b0) begin
                    failures++;
                    $display("FAIL burst_full accepted=%0d ready=%b expected accepted=5 ready=0", idx, ready_out);
                end
            end
            begin : capturer
                int n;
                logic [10:0] bits;
                logic st;
                wait_start(20, n);
                checks++;
                if (n !== 2) begin
                    failures++;
                    $display("FAIL burst_latency edges=%0d expected 2", n);
                end
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        checks++;
                        if (tx !== 1'b0) begin
                            failures++;
                            $display("FAIL burst_gap frame=%0d tx=%b expected 0", k, tx);
                        end
                    end
                    capture_frame(bits, st);
                    checks++;
                    if (bits !== frame_of(q[k]) || st !== 1'b1) begin
                        failures++;
                        $display("FAIL burst_frame frame=%0d bits=%b stable=%b expected %b stable=1", k, bits, st, frame_of(q[k]));
                    end
                end
                @(negedge clk);
                checks++;
                if (busy !== 1'b0 || tx !== 1'b1) begin
                    failures++;
                    $display("FAIL burst_done busy=%b tx=%b expected busy=0 tx=1", busy, tx);
                end
            end
        join
    endtask

    task automatic test_reset_abort();
        int k;
        logic stayed;
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'hC3;
        @(negedge clk);
        data_in = 8'h11;
        @(negedge clk);
        data_in = 8'h22;
        k = 1;
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL abort_start tx=%b expected 0", tx);
        end
        while (k < 40) begin
            @(negedge clk);
            k++;
            valid_in = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre busy=%b expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0 || ready_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_immediate tx=%b busy=%b ready=%b expected tx=1 busy=0 ready=0", tx, busy, ready_out);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_release ready=%b busy=%b expected ready=1 busy=0", ready_out, busy);
        end
        stayed = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) stayed = 1'b0;
        end
        checks++;
        if (stayed !== 1'b1) begin
            failures++;
            $display("FAIL abort_fifo_empty line_quiet=%b expected 1", stayed);
        end
    endtask

    task automatic test_full_pop();
        int k;
        logic [10:0] bits;
        logic st;
        logic [7:0] rest [4];
        rest = '{8'h04, 8'h08, 8'h10, 8'h5A};
        do_reset();
        valid_in = 1'b1;
        data_in  = 8'h01;
        @(negedge clk);
        data_in = 8'h02;
        @(negedge clk);
        k = 1;
        data_in = 8'h04;
        @(negedge clk);
        k++;
        data_in = 8'h08;
        @(negedge clk);
        k++;
        data_in = 8'h10;
        @(negedge clk);
        k++;
        data_in = 8'h5A;
        checks++;
        if (ready_out !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_full ready=%b expected 0", ready_out);
        end
        while (k < FRAME_CYC) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (ready_out !== 1'b0 || tx !== 1'b1) begin
            failures++;
            $display("FAIL fullpop_before_pop ready=%b tx=%b expected ready=0 tx=1", ready_out, tx);
        end
        @(negedge clk);
        checks++;
        if (ready_out !== 1'b1 || tx !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_after_pop ready=%b tx=%b expected ready=1 tx=0", ready_out, tx);
        end
        @(negedge clk);
        valid_in = 1'b0;
        checks++;
        if (ready_out !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_reaccept ready=%b expected 0", ready_out);
        end
        repeat (FRAME_CYC - 2) @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b0) begin
                failures++;
                $display("FAIL fullpop_gap frame=%0d tx=%b expected 0", f, tx);
            end
            capture_frame(bits, st);
            checks++;
            if (bits !== frame_of(rest[f]) || st !== 1'b1) begin
                failures++;
                $display("FAIL fullpop_frame frame=%0d bits=%b stable=%b expected %b stable=1", f, bits, st, frame_of(rest[f]));
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fullpop_done busy=%b expected 0", busy);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        logic [10:0] bits;
        logic st;
        logic [7:0] pb [2];
        logic [10:0] pe [2];
        pb = '{8'h07, 8'h03};
        pe = '{11'b11000001110, 11'b10000000110};
        do_reset();
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            data_in  = pb[i];
            @(negedge clk);
            valid_in = 1'b0;
            wait_start(20, n);
            capture_frame(bits, st);
            checks++;
            if (n !== 1 || bits !== pe[i] || st !== 1'b1) begin
                failures++;
                $display("FAIL parity_frame byte=%h bits=%b stable=%b latency=%0d expected %b stable=1 latency=1", pb[i], bits, st, n, pe[i]);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL parity_done byte=%h busy=%b expected 0", pb[i], busy);
            end
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        data_in  = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_abort();
        test_full_pop();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
